// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: definitions shared by the RI5CY load/store unit and its
// load-data aligner.
//   - LSU_BYTE / LSU_HALF / LSU_WORD : data_type encodings (2'b11 acts as word)
//   - lsu_state_t                    : bus handshake FSM states
//   - be_gen()                       : byte enables for the first or second phase
//   - is_misaligned()                : access crosses a word boundary
package riscv_lsu_pkg;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } lsu_state_t;

  function automatic logic [3:0] be_gen(input logic [1:0] dtype,
                                        input logic [1:0] off,
                                        input logic       second);
    logic [3:0] be;
    if (second) begin
      // Second phase only exists for word (off 1..3) and half (off 3).
      if (dtype == LSU_HALF) be = 4'b0001;
      else                   be = 4'b1111 >> (3'd4 - {1'b0, off});
    end else begin
      case (dtype)
        LSU_BYTE: be = 4'b0001 << off;
        LSU_HALF: be = 4'b0011 << off;
        default:  be = 4'b1111 << off;
      endcase
    end
    return be;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] dtype,
                                         input logic [1:0] off);
    if (dtype == LSU_BYTE)      return 1'b0;
    else if (dtype == LSU_HALF) return (off == 2'd3);
    else                        return (off != 2'd0);
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: combinational load-data aligner. Rotates the returned bus
// word(s) down by the byte offset, merges both halves of a split access and
// sign/zero-extends byte and halfword results. Also used by the debug memory
// path.
//   i_rdata      : bus data of the final (or only) response
//   i_rdata_1st  : bus data of the first response of a split access
//   i_split      : access was split into two bus transactions
//   i_off        : byte offset of the original address
//   i_type       : LSU_BYTE / LSU_HALF / LSU_WORD
//   i_sign       : sign-extend byte/half results
//   o_rdata      : aligned, extended load data
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_rdata_1st,
  input  logic        i_split,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_type,
  input  logic        i_sign,
  output logic [31:0] o_rdata
);

  logic [63:0] w_cat;
  logic [31:0] w_raw;

  always_comb begin
    w_cat = i_split ? {i_rdata, i_rdata_1st} : {32'h0, i_rdata};
    w_raw = 32'(w_cat >> {i_off, 3'b000});
    case (i_type)
      LSU_BYTE: o_rdata = {{24{i_sign & w_raw[7]}},  w_raw[7:0]};
      LSU_HALF: o_rdata = {{16{i_sign & w_raw[15]}}, w_raw[15:0]};
      default:  o_rdata = w_raw;
    endcase
  end

endmodule

// File: rtl/riscv_lsu_wb_stage.sv
// riscv_lsu_wb_stage: RI5CY load/store unit spanning EX/WB. Computes the data
// address, runs the req/gnt/rvalid handshake (one outstanding transaction),
// aligns load data and registers it for writeback.
//   EX side  : data_req_ex_i, data_we_ex_i, data_type_ex_i, data_sign_ext_ex_i,
//              operand_a_ex_i, operand_b_ex_i, data_wdata_ex_i, ex_valid_i
//   Status   : lsu_ready_ex_o, lsu_ready_wb_o, data_misaligned_o,
//              data_err_misaligned_o
//   WB data  : lsu_rdata_o, lsu_rvalid_o (one cycle after the final rvalid)
//   Bus      : data_req_o, data_gnt_i, data_rvalid_i, data_addr_o, data_we_o,
//              data_be_o, data_wdata_o, data_rdata_i
// Build option: define RISCV_LSU_MISALIGNED_EN to split misaligned accesses
// into two bus transactions; otherwise they are rejected with a one-cycle
// data_err_misaligned_o pulse and never reach the bus.
module riscv_lsu_wb_stage
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_ex_i,
  input  logic                  data_we_ex_i,
  input  logic [1:0]            data_type_ex_i,
  input  logic                  data_sign_ext_ex_i,
  input  logic [31:0]           operand_a_ex_i,
  input  logic [31:0]           operand_b_ex_i,
  input  logic [31:0]           data_wdata_ex_i,
  input  logic                  ex_valid_i,
  output logic                  lsu_ready_ex_o,
  output logic                  lsu_ready_wb_o,
  output logic [31:0]           lsu_rdata_o,
  output logic                  lsu_rvalid_o,
  output logic                  data_misaligned_o,
  output logic                  data_err_misaligned_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic [31:0]           data_rdata_i
);

  lsu_state_t r_state, w_state_next;

  logic [1:0]            r_type, r_off;
  logic                  r_sign, r_we;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [3:0]            r_bus_be;
  logic [31:0]           r_bus_wdata;
  logic                  r_bus_we;
  logic [31:0]           r_rdata;
  logic                  r_rvalid;

  logic [31:0]           w_addr, w_wdata_rot, w_aligned, w_rdata_1st;
  logic [1:0]            w_off;
  logic                  w_misal, w_final, w_split, w_new_slot, w_new_done;
  logic                  w_issue_new, w_issue_2nd, w_err;
  logic                  w_req, w_we, w_ready_ex, w_ready_wb;
  logic [ADDR_WIDTH-1:0] w_bus_addr;
  logic [3:0]            w_bus_be;
  logic [31:0]           w_bus_wdata;

  // Control fields are latched when the access is issued to the bus instead.
  logic w_unused_ex_valid;
  assign w_unused_ex_valid = ex_valid_i;

  assign w_addr      = operand_a_ex_i + operand_b_ex_i;
  assign w_off       = w_addr[1:0];
  assign w_misal     = is_misaligned(data_type_ex_i, w_off);
  assign w_wdata_rot = 32'({data_wdata_ex_i, data_wdata_ex_i} >> (6'd32 - {1'b0, w_off, 3'b000}));

`ifdef RISCV_LSU_MISALIGNED_EN
  logic                  r_split, r_second;
  logic [31:0]           r_rdata_1st, r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;

  assign w_split     = r_split;
  assign w_rdata_1st = r_rdata_1st;
  assign w_final     = !r_split || r_second;
  assign w_err       = 1'b0;
  assign w_issue_2nd = (r_state == WAIT_RVALID) && data_rvalid_i && !w_final;
  assign w_new_done  = !data_req_ex_i || (data_gnt_i && !w_misal);
  assign data_misaligned_o = !rst && (r_state == WAIT_RVALID) && r_split && !r_second;
`else
  assign w_split     = 1'b0;
  assign w_rdata_1st = '0;
  assign w_final     = 1'b1;
  assign w_err       = w_new_slot && data_req_ex_i && w_misal;
  assign w_issue_2nd = 1'b0;
  assign w_new_done  = !data_req_ex_i || w_misal || data_gnt_i;
  assign data_misaligned_o = 1'b0;
`endif

  // A new EX request may go out from IDLE or in the cycle the final response
  // of the previous access returns (back-to-back).
  assign w_new_slot  = (r_state == IDLE) ||
                       ((r_state == WAIT_RVALID) && data_rvalid_i && w_final);
  assign w_issue_new = w_new_slot && data_req_ex_i && !(w_misal && !w_split_ok());

  function automatic logic w_split_ok();
`ifdef RISCV_LSU_MISALIGNED_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_bus_addr   = '0;
    w_bus_be     = '0;
    w_bus_wdata  = '0;
    w_ready_ex   = 1'b0;
    w_ready_wb   = 1'b1;
    case (r_state)
      IDLE:     w_ready_ex = w_new_done;
      WAIT_GNT: begin
        w_req       = 1'b1;
        w_we        = r_bus_we;
        w_bus_addr  = r_bus_addr;
        w_bus_be    = r_bus_be;
        w_bus_wdata = r_bus_wdata;
        w_ready_ex  = data_gnt_i && w_final;
        if (data_gnt_i) w_state_next = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        w_ready_wb = data_rvalid_i && w_final;
        if (!w_final) w_ready_ex = w_issue_2nd && data_gnt_i;
        else          w_ready_ex = !data_req_ex_i || (data_rvalid_i && w_new_done);
        if (data_rvalid_i && w_final) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

`ifdef RISCV_LSU_MISALIGNED_EN
    if (w_issue_2nd) begin
      w_req        = 1'b1;
      w_we         = r_we;
      w_bus_addr   = r_addr + ADDR_WIDTH'(4);
      w_bus_be     = be_gen(r_type, r_off, 1'b1);
      w_bus_wdata  = r_wdata;
      w_state_next = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
    end
`endif
    if (w_issue_new) begin
      w_req        = 1'b1;
      w_we         = data_we_ex_i;
      w_bus_addr   = {w_addr[ADDR_WIDTH-1:2], 2'b00};
      w_bus_be     = be_gen(data_type_ex_i, w_off, 1'b0);
      w_bus_wdata  = w_wdata_rot;
      w_state_next = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
    end

    if (rst) begin
      w_state_next = IDLE;
      w_req        = 1'b0;
      w_we         = 1'b0;
      w_bus_addr   = '0;
      w_bus_be     = '0;
      w_bus_wdata  = '0;
      w_ready_ex   = 1'b1;
      w_ready_wb   = 1'b1;
    end
  end

  riscv_lsu_align u_align (
    .i_rdata     (data_rdata_i),
    .i_rdata_1st (w_rdata_1st),
    .i_split     (w_split),
    .i_off       (r_off),
    .i_type      (r_type),
    .i_sign      (r_sign),
    .o_rdata     (w_aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_type      <= '0;
      r_off       <= '0;
      r_sign      <= 1'b0;
      r_we        <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_bus_we    <= 1'b0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
`ifdef RISCV_LSU_MISALIGNED_EN
      r_split     <= 1'b0;
      r_second    <= 1'b0;
      r_rdata_1st <= '0;
      r_wdata     <= '0;
      r_addr      <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_rvalid <= 1'b0;
      // Snapshot of whatever is driven; frozen while waiting for the grant.
      if (r_state != WAIT_GNT) begin
        r_bus_addr  <= w_bus_addr;
        r_bus_be    <= w_bus_be;
        r_bus_wdata <= w_bus_wdata;
        r_bus_we    <= w_we;
      end
      if ((r_state == WAIT_RVALID) && data_rvalid_i && w_final && !r_we) begin
        r_rdata  <= w_aligned;
        r_rvalid <= 1'b1;
      end
      if (w_issue_new) begin
        r_type <= data_type_ex_i;
        r_off  <= w_off;
        r_sign <= data_sign_ext_ex_i;
        r_we   <= data_we_ex_i;
      end
`ifdef RISCV_LSU_MISALIGNED_EN
      if (w_issue_new) begin
        r_split  <= w_misal;
        r_second <= 1'b0;
        r_wdata  <= w_wdata_rot;
        r_addr   <= {w_addr[ADDR_WIDTH-1:2], 2'b00};
      end else if (w_issue_2nd) begin
        r_second    <= 1'b1;
        r_rdata_1st <= data_rdata_i;
      end
`endif
    end
  end

  assign data_req_o            = w_req;
  assign data_we_o             = w_we;
  assign data_addr_o           = w_bus_addr;
  assign data_be_o             = w_bus_be;
  assign data_wdata_o          = w_bus_wdata;
  assign lsu_ready_ex_o        = w_ready_ex;
  assign lsu_ready_wb_o        = w_ready_wb;
  assign data_err_misaligned_o = w_err && !rst;
  assign lsu_rdata_o           = r_rdata;
  assign lsu_rvalid_o          = r_rvalid;

endmodule

// File: tb/tb_riscv_lsu_wb_stage.sv
module tb_riscv_lsu_wb_stage;

  logic        clk, rst;
  logic        data_req_ex_i, data_we_ex_i, data_sign_ext_ex_i, ex_valid_i;
  logic [1:0]  data_type_ex_i;
  logic [31:0] operand_a_ex_i, operand_b_ex_i, data_wdata_ex_i;
  logic        lsu_ready_ex_o, lsu_ready_wb_o, lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        data_misaligned_o, data_err_misaligned_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [1:0]  dtype;
    logic        sign;
    logic [31:0] a, b, wdata, rdata;
    int unsigned gnt_delay;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_rdata;
  } vec_t;

  vec_t vecs[10];

  riscv_lsu_wb_stage #(.ADDR_WIDTH(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .data_req_ex_i         (data_req_ex_i),
    .data_we_ex_i          (data_we_ex_i),
    .data_type_ex_i        (data_type_ex_i),
    .data_sign_ext_ex_i    (data_sign_ext_ex_i),
    .operand_a_ex_i        (operand_a_ex_i),
    .operand_b_ex_i        (operand_b_ex_i),
    .data_wdata_ex_i       (data_wdata_ex_i),
    .ex_valid_i            (ex_valid_i),
    .lsu_ready_ex_o        (lsu_ready_ex_o),
    .lsu_ready_wb_o        (lsu_ready_wb_o),
    .lsu_rdata_o           (lsu_rdata_o),
    .lsu_rvalid_o          (lsu_rvalid_o),
    .data_misaligned_o     (data_misaligned_o),
    .data_err_misaligned_o (data_err_misaligned_o),
    .data_req_o            (data_req_o),
    .data_gnt_i            (data_gnt_i),
    .data_rvalid_i         (data_rvalid_i),
    .data_addr_o           (data_addr_o),
    .data_we_o             (data_we_o),
    .data_be_o             (data_be_o),
    .data_wdata_o          (data_wdata_o),
    .data_rdata_i          (data_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every lsu_rvalid_o pulse must match the oldest expected load.
  task automatic sample();
    logic [31:0] e;
    @(negedge clk);
    if (lsu_rvalid_o) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_rvalid: got rdata 0x%08h required no pulse", lsu_rdata_o);
      end else begin
        e = exp_q.pop_front();
        check("sb_rdata", lsu_rdata_o, e);
      end
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic we, input logic [1:0] dt, input logic sg,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd);
    data_req_ex_i      = 1'b1;
    data_we_ex_i       = we;
    data_type_ex_i     = dt;
    data_sign_ext_ex_i = sg;
    operand_a_ex_i     = a;
    operand_b_ex_i     = b;
    data_wdata_ex_i    = wd;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    drive_ex(v.we, v.dtype, v.sign, v.a, v.b, v.wdata);
    if (!v.we) exp_q.push_back(v.exp_rdata);
    for (int k = 0; k <= int'(v.gnt_delay); k++) begin
      data_gnt_i = (k == int'(v.gnt_delay));
      sample();
      check($sformatf("v%0d_c%0d_req", idx, k), data_req_o, 1);
      check($sformatf("v%0d_c%0d_addr", idx, k), data_addr_o, v.exp_addr);
      check($sformatf("v%0d_c%0d_be", idx, k), data_be_o, v.exp_be);
      check($sformatf("v%0d_c%0d_we", idx, k), data_we_o, v.we);
      if (v.we) check($sformatf("v%0d_c%0d_wdata", idx, k), data_wdata_o, v.exp_wdata);
      check($sformatf("v%0d_c%0d_ready_ex", idx, k), lsu_ready_ex_o, (k == int'(v.gnt_delay)));
      nxt();
    end
    data_req_ex_i = 1'b0;
    data_gnt_i    = 1'b0;
    sample();
    check($sformatf("v%0d_ready_wb_wait", idx), lsu_ready_wb_o, 0);
    nxt();
    data_rvalid_i = 1'b1;
    data_rdata_i  = v.rdata;
    sample();
    check($sformatf("v%0d_ready_wb_rvalid", idx), lsu_ready_wb_o, 1);
    check($sformatf("v%0d_req_idle", idx), data_req_o, 0);
    nxt();
    data_rvalid_i = 1'b0;
    sample();
    check($sformatf("v%0d_lsu_rvalid", idx), lsu_rvalid_o, !v.we);
    nxt();
  endtask

  task automatic misal_seq(input string nm, input logic [1:0] dt, input logic sg,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] addr1, input logic [3:0] be1,
                           input logic [3:0] be2, input logic [31:0] exp_rd);
    drive_ex(1'b0, dt, sg, a, b, 32'h0);
`ifdef RISCV_LSU_MISALIGNED_EN
    exp_q.push_back(exp_rd);
    data_gnt_i = 1'b1;
    sample();
    check({nm, "_addr1"}, data_addr_o, addr1);
    check({nm, "_be1"}, data_be_o, be1);
    check({nm, "_ready_ex1"}, lsu_ready_ex_o, 0);
    nxt();
    data_gnt_i = 1'b0;
    sample();
    check({nm, "_misaligned"}, data_misaligned_o, 1);
    check({nm, "_req_gap"}, data_req_o, 0);
    nxt();
    data_rvalid_i = 1'b1;
    data_rdata_i  = rd1;
    data_gnt_i    = 1'b1;
    sample();
    check({nm, "_addr2"}, data_addr_o, addr1 + 32'd4);
    check({nm, "_be2"}, data_be_o, be2);
    check({nm, "_ready_ex2"}, lsu_ready_ex_o, 1);
    check({nm, "_ready_wb_1st"}, lsu_ready_wb_o, 0);
    nxt();
    data_req_ex_i = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    sample();
    check({nm, "_misaligned_off"}, data_misaligned_o, 0);
    nxt();
    data_rvalid_i = 1'b1;
    data_rdata_i  = rd2;
    sample();
    check({nm, "_ready_wb_2nd"}, lsu_ready_wb_o, 1);
    nxt();
    data_rvalid_i = 1'b0;
    sample();
    check({nm, "_lsu_rvalid"}, lsu_rvalid_o, 1);
    check({nm, "_err"}, data_err_misaligned_o, 0);
    nxt();
`else
    data_gnt_i = 1'b1;
    sample();
    check({nm, "_no_req"}, data_req_o, 0);
    check({nm, "_err_pulse"}, data_err_misaligned_o, 1);
    check({nm, "_ready_ex"}, lsu_ready_ex_o, 1);
    check({nm, "_misaligned_tied"}, data_misaligned_o, 0);
    nxt();
    data_req_ex_i = 1'b0;
    data_gnt_i    = 1'b0;
    sample();
    check({nm, "_err_end"}, data_err_misaligned_o, 0);
    nxt();
    sample();
    check({nm, "_no_rvalid"}, lsu_rvalid_o, 0);
    nxt();
`endif
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'b10, 1'b0, 32'h0F0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 2'b00, 1'b1, 32'h100, 32'h3, 32'h0, 32'h80112233, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80};
    vecs[2] = '{1'b0, 2'b00, 1'b0, 32'h100, 32'h3, 32'h0, 32'h80112233, 1, 32'h100, 4'b1000, 32'h0, 32'h00000080};
    vecs[3] = '{1'b1, 2'b01, 1'b0, 32'h100, 32'h2, 32'h0000ABCD, 32'h0, 3, 32'h100, 4'b1100, 32'hABCD0000, 32'h0};
    vecs[4] = '{1'b0, 2'b01, 1'b1, 32'h100, 32'h2, 32'h0, 32'h80011234, 0, 32'h100, 4'b1100, 32'h0, 32'hFFFF8001};
    vecs[5] = '{1'b1, 2'b00, 1'b0, 32'h101, 32'h0, 32'h000000A5, 32'h0, 1, 32'h100, 4'b0010, 32'h0000A500, 32'h0};
    vecs[6] = '{1'b0, 2'b11, 1'b1, 32'h200, 32'h4, 32'h0, 32'h12345678, 2, 32'h204, 4'b1111, 32'h0, 32'h12345678};
    vecs[7] = '{1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0BADF00D, 0, 32'h004, 4'b1111, 32'h0, 32'h0BADF00D};
    vecs[8] = '{1'b0, 2'b01, 1'b0, 32'h100, 32'h1, 32'h0, 32'hAA8FE100, 0, 32'h100, 4'b0110, 32'h0, 32'h00008FE1};
    vecs[9] = '{1'b1, 2'b10, 1'b0, 32'h300, 32'h0, 32'h01234567, 32'h0, 0, 32'h300, 4'b1111, 32'h01234567, 32'h0};

    rst = 1'b1;
    data_req_ex_i = 1'b0; data_we_ex_i = 1'b0; data_type_ex_i = 2'b00;
    data_sign_ext_ex_i = 1'b0; operand_a_ex_i = '0; operand_b_ex_i = '0;
    data_wdata_ex_i = '0; ex_valid_i = 1'b0; data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0; data_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    sample();
    check("rst_ready_ex", lsu_ready_ex_o, 1);
    check("rst_ready_wb", lsu_ready_wb_o, 1);
    check("rst_req", data_req_o, 0);
    check("rst_rvalid", lsu_rvalid_o, 0);
    check("rst_rdata", lsu_rdata_o, 0);
    check("rst_misaligned", data_misaligned_o, 0);
    check("rst_err", data_err_misaligned_o, 0);
    nxt();
    rst = 1'b0;
    nxt();

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    misal_seq("mis_word", 2'b10, 1'b0, 32'h200, 32'h1, 32'h44332211, 32'h88776655,
              32'h200, 4'b1110, 4'b0001, 32'h55443322);
    misal_seq("mis_half", 2'b01, 1'b1, 32'h100, 32'h3, 32'hAB000000, 32'h000000CD,
              32'h100, 4'b1000, 4'b0001, 32'hFFFFCDAB);

    // Back-to-back: second load issued in the cycle of the first rvalid.
    drive_ex(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0);
    exp_q.push_back(32'h11111111);
    data_gnt_i = 1'b1;
    sample();
    check("b2b_req1", data_req_o, 1);
    nxt();
    drive_ex(1'b0, 2'b10, 1'b0, 32'h300, 32'h4, 32'h0);
    exp_q.push_back(32'h22222222);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h11111111;
    sample();
    check("b2b_req2", data_req_o, 1);
    check("b2b_addr2", data_addr_o, 32'h304);
    check("b2b_ready_wb", lsu_ready_wb_o, 1);
    check("b2b_ready_ex", lsu_ready_ex_o, 1);
    nxt();
    data_req_ex_i = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    sample();
    check("b2b_rvalid1", lsu_rvalid_o, 1);
    check("b2b_wait_wb", lsu_ready_wb_o, 0);
    nxt();
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h22222222;
    sample();
    nxt();
    data_rvalid_i = 1'b0;
    sample();
    check("b2b_rvalid2", lsu_rvalid_o, 1);
    nxt();

    // Reset while waiting for a grant; a late rvalid must be ignored.
    drive_ex(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0);
    data_gnt_i = 1'b0;
    sample();
    nxt();
    sample();
    check("rstg_req_held", data_req_o, 1);
    check("rstg_addr_held", data_addr_o, 32'h400);
    nxt();
    rst = 1'b1;
    sample();
    check("rstg_req_drop", data_req_o, 0);
    check("rstg_ready_ex", lsu_ready_ex_o, 1);
    check("rstg_ready_wb", lsu_ready_wb_o, 1);
    nxt();
    rst = 1'b0;
    data_req_ex_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h5A5A5A5A;
    sample();
    check("rstg_idle_req", data_req_o, 0);
    check("rstg_idle_wb", lsu_ready_wb_o, 1);
    nxt();
    data_rvalid_i = 1'b0;
    sample();
    check("rstg_late_rvalid", lsu_rvalid_o, 0);
    nxt();

    sample();
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
